csr_sys_exu: RTL and testbench

- Execute-stage unit for RISC-V Zicsr and system instructions (CSRRW/S/C, immediate forms, ECALL, MRET).
- Sits between the decode stage and the machine CSR register file, and drives that register file's read/write/ecall/mret controls.
- Computes rd writeback data and the trap or return redirect PC.
- Returns results to writeback over a valid/ready handshake.

---
 rtl/csr_sys_exu.sv | 163 ++++++++++++++++
 tb/tb_csr_sys_exu.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_sys_exu.sv
`default_nettype none
// ============================================================================
// Module      : csr_sys_exu
// Description : Execute unit for Zicsr instructions, ECALL and MRET. It drives
//               the machine CSR file controls and returns rd data or a redirect.
// Revision    : 1.0 - initial release
// ============================================================================
module csr_sys_exu #(
    parameter int DATA_W     = 32,
    parameter int CSR_ADDR_W = 12
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_pc,
    input  logic [2:0]            in_funct3,
    input  logic                  in_is_ecall,
    input  logic                  in_is_mret,
    input  logic [CSR_ADDR_W-1:0] in_csr_addr,
    input  logic [4:0]            in_rs1_idx,
    input  logic [DATA_W-1:0]     in_rs1_data,
    input  logic [4:0]            in_rd,
    output logic [CSR_ADDR_W-1:0] csr_raddr,
    input  logic [DATA_W-1:0]     csr_rdata,
    output logic                  csr_wen,
    output logic [CSR_ADDR_W-1:0] csr_waddr,
    output logic [DATA_W-1:0]     csr_wdata,
    output logic                  csr_ecall,
    output logic                  csr_mret,
    output logic [DATA_W-1:0]     csr_pc,
    input  logic [DATA_W-1:0]     csr_mepc,
    input  logic [DATA_W-1:0]     csr_mtvec,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4:0]            out_rd,
    output logic                  out_rd_wen,
    output logic [DATA_W-1:0]     out_rd_data,
    output logic                  out_redirect,
    output logic [DATA_W-1:0]     out_redirect_pc
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                r_state;
    logic [DATA_W-1:0]     r_pc;
    logic [DATA_W-1:0]     r_rs1_data;
    logic [2:0]            r_funct3;
    logic                  r_is_ecall;
    logic                  r_is_mret;
    logic [CSR_ADDR_W-1:0] r_csr_addr;
    logic [4:0]            r_rs1_idx;
    logic [4:0]            r_rd;

    logic                  w_exec;
    logic                  w_csr_op;
    logic                  w_do_write;
    logic [DATA_W-1:0]     w_src;
    logic [DATA_W-1:0]     w_new;

    assign w_exec   = (r_state == EXEC);
    // System instructions take priority over whatever funct3 happens to hold
    assign w_csr_op = (r_funct3[1:0] != 2'b00) && !r_is_ecall && !r_is_mret;
    assign w_src    = r_funct3[2] ? {{(DATA_W-5){1'b0}}, r_rs1_idx} : r_rs1_data;

    always_comb begin
        w_new = csr_rdata;
        case (r_funct3[1:0])
            2'b01:   w_new = w_src;
            2'b10:   w_new = csr_rdata | w_src;
            2'b11:   w_new = csr_rdata & ~w_src;
            default: w_new = csr_rdata;
        endcase
    end

    // Set/clear with rs1/zimm == 0 is a pure read and must not write
    assign w_do_write = w_csr_op && ((r_funct3[1:0] == 2'b01) || (r_rs1_idx != 5'd0));

    // CSR controls exist only in EXEC, so reset and the other states force them low
    assign in_ready  = (r_state == IDLE);
    assign csr_raddr = w_exec ? r_csr_addr : '0;
    assign csr_wen   = w_exec && w_do_write;
    assign csr_waddr = csr_wen ? r_csr_addr : '0;
    assign csr_wdata = csr_wen ? w_new : '0;
    assign csr_ecall = w_exec && r_is_ecall;
    assign csr_mret  = w_exec && r_is_mret && !r_is_ecall;
    assign csr_pc    = csr_ecall ? r_pc : '0;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state         <= IDLE;
            r_pc            <= '0;
            r_rs1_data      <= '0;
            r_funct3        <= '0;
            r_is_ecall      <= 1'b0;
            r_is_mret       <= 1'b0;
            r_csr_addr      <= '0;
            r_rs1_idx       <= '0;
            r_rd            <= '0;
            out_valid       <= 1'b0;
            out_rd          <= '0;
            out_rd_wen      <= 1'b0;
            out_rd_data     <= '0;
            out_redirect    <= 1'b0;
            out_redirect_pc <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_pc       <= in_pc;
                        r_rs1_data <= in_rs1_data;
                        r_funct3   <= in_funct3;
                        r_is_ecall <= in_is_ecall;
                        r_is_mret  <= in_is_mret;
                        r_csr_addr <= in_csr_addr;
                        r_rs1_idx  <= in_rs1_idx;
                        r_rd       <= in_rd;
                        r_state    <= EXEC;
                    end
                end
                EXEC: begin
                    out_valid <= 1'b1;
                    out_rd    <= r_rd;
                    if (r_is_ecall) begin
                        out_rd_wen      <= 1'b0;
                        out_rd_data     <= '0;
                        out_redirect    <= 1'b1;
                        out_redirect_pc <= csr_mtvec;
                    end else if (r_is_mret) begin
                        out_rd_wen      <= 1'b0;
                        out_rd_data     <= '0;
                        out_redirect    <= 1'b1;
                        out_redirect_pc <= csr_mepc;
                    end else if (w_csr_op) begin
                        out_rd_wen      <= (r_rd != 5'd0);
                        out_rd_data     <= csr_rdata;
                        out_redirect    <= 1'b0;
                        out_redirect_pc <= '0;
                    end else begin
                        out_rd_wen      <= 1'b0;
                        out_rd_data     <= '0;
                        out_redirect    <= 1'b0;
                        out_redirect_pc <= '0;
                    end
                    r_state <= RESP;
                end
                RESP: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_csr_sys_exu.sv
`default_nettype none
// ============================================================================
// Module      : tb_csr_sys_exu
// Description : Table-driven and randomized checks of csr_sys_exu.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_csr_sys_exu;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid, in_ready;
    logic [31:0] in_pc;
    logic [2:0]  in_funct3;
    logic        in_is_ecall, in_is_mret;
    logic [11:0] in_csr_addr;
    logic [4:0]  in_rs1_idx;
    logic [31:0] in_rs1_data;
    logic [4:0]  in_rd;
    logic [11:0] csr_raddr;
    logic [31:0] csr_rdata;
    logic        csr_wen;
    logic [11:0] csr_waddr;
    logic [31:0] csr_wdata;
    logic        csr_ecall, csr_mret;
    logic [31:0] csr_pc, csr_mepc, csr_mtvec;
    logic        out_valid, out_ready;
    logic [4:0]  out_rd;
    logic        out_rd_wen;
    logic [31:0] out_rd_data;
    logic        out_redirect;
    logic [31:0] out_redirect_pc;

    logic [11:0] cur_addr;
    logic [31:0] cur_old;
    int          n_vec  = 0;
    int          n_fail = 0;

    always #5 clock = ~clock;

    // The CSR file answers with the chosen old value only at the expected address
    assign csr_rdata = (csr_raddr == cur_addr) ? cur_old : 32'hDEAD_BEEF;

    csr_sys_exu #(.DATA_W(32), .CSR_ADDR_W(12)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
        .in_funct3(in_funct3), .in_is_ecall(in_is_ecall), .in_is_mret(in_is_mret),
        .in_csr_addr(in_csr_addr), .in_rs1_idx(in_rs1_idx), .in_rs1_data(in_rs1_data),
        .in_rd(in_rd), .csr_raddr(csr_raddr), .csr_rdata(csr_rdata),
        .csr_wen(csr_wen), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
        .csr_ecall(csr_ecall), .csr_mret(csr_mret), .csr_pc(csr_pc),
        .csr_mepc(csr_mepc), .csr_mtvec(csr_mtvec),
        .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd),
        .out_rd_wen(out_rd_wen), .out_rd_data(out_rd_data),
        .out_redirect(out_redirect), .out_redirect_pc(out_redirect_pc)
    );

    typedef struct {
        logic [2:0]  f3;
        logic        ec, mr;
        logic [11:0] addr;
        logic [4:0]  idx;
        logic [31:0] data;
        logic [4:0]  rd;
        logic [31:0] pc, old, mtvec, mepc;
        int          stall;
        logic        e_wen, e_ec, e_mr, e_rdwen, e_csrop, e_redir;
        logic [31:0] e_wdata, e_rddata, e_rpc;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (vector %0d): got %h, expected %h", nm, n_vec, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] f3, input logic ec, input logic mr,
                                input logic [11:0] addr, input logic [4:0] idx,
                                input logic [31:0] data, input logic [4:0] rd,
                                input logic [31:0] pc, input logic [31:0] old,
                                input logic [31:0] mtvec, input logic [31:0] mepc,
                                input int stall);
        vec_t v;
        v = '{default: '0};
        v.f3 = f3; v.ec = ec; v.mr = mr; v.addr = addr; v.idx = idx; v.data = data;
        v.rd = rd; v.pc = pc; v.old = old; v.mtvec = mtvec; v.mepc = mepc; v.stall = stall;
        return v;
    endfunction

    function automatic vec_t ex(input vec_t vi, input logic wen, input logic [31:0] wdata,
                                input logic ec, input logic mr, input logic csrop,
                                input logic rdwen, input logic [31:0] rddata,
                                input logic redir, input logic [31:0] rpc);
        vec_t v;
        v = vi;
        v.e_wen = wen; v.e_wdata = wdata; v.e_ec = ec; v.e_mr = mr; v.e_csrop = csrop;
        v.e_rdwen = rdwen; v.e_rddata = rddata; v.e_redir = redir; v.e_rpc = rpc;
        return v;
    endfunction

    // Reference: instruction semantics straight from the ISA rules
    function automatic vec_t model(input vec_t vi);
        vec_t        v;
        logic [31:0] src, nv;
        int          op;
        v = ex(vi, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        op = int'(vi.f3) % 4;
        if (vi.ec) begin
            v.e_ec = 1; v.e_redir = 1; v.e_rpc = vi.mtvec;
        end else if (vi.mr) begin
            v.e_mr = 1; v.e_redir = 1; v.e_rpc = vi.mepc;
        end else if (op != 0) begin
            src = (vi.f3 >= 3'd4) ? 32'(vi.idx) : vi.data;
            if (op == 1)      nv = src;
            else if (op == 2) nv = vi.old | src;
            else              nv = vi.old & ~src;
            v.e_csrop  = 1;
            v.e_rddata = vi.old;
            v.e_rdwen  = (vi.rd != 0);
            v.e_wen    = (op == 1) || (vi.idx != 0);
            v.e_wdata  = nv;
        end
        return v;
    endfunction

    task automatic apply(input vec_t v);
        int          k, stl, lat, nwen, nec, nmr;
        logic        got, done, unstable, rdybad, pv, pr;
        logic [31:0] waddr, wdata, cpc, o_rddata, o_rpc;
        logic [4:0]  o_rd;
        logic        o_rdwen, o_redir;
        k = 0; stl = 0; lat = -1; nwen = 0; nec = 0; nmr = 0;
        got = 0; done = 0; unstable = 0; rdybad = 0; pv = 1; pr = 0;
        waddr = 0; wdata = 0; cpc = 0; o_rddata = 0; o_rpc = 0; o_rd = 0;
        o_rdwen = 0; o_redir = 0;
        cur_addr = v.addr; cur_old = v.old; csr_mtvec = v.mtvec; csr_mepc = v.mepc;
        in_pc = v.pc; in_funct3 = v.f3; in_is_ecall = v.ec; in_is_mret = v.mr;
        in_csr_addr = v.addr; in_rs1_idx = v.idx; in_rs1_data = v.data; in_rd = v.rd;
        in_valid = 1; out_ready = 0;
        chk("accept_ready", in_ready, 1);
        while (!done && k < 40) begin
            @(negedge clock);
            k++;
            in_valid = 0;
            if (csr_wen)   begin nwen++; waddr = 32'(csr_waddr); wdata = csr_wdata; end
            if (csr_ecall) begin nec++; cpc = csr_pc; end
            if (csr_mret)  nmr++;
            if (in_ready)  rdybad = 1;
            if (out_valid) begin
                if (!got) begin
                    got = 1; lat = k; o_rd = out_rd; o_rdwen = out_rd_wen;
                    o_rddata = out_rd_data; o_redir = out_redirect; o_rpc = out_redirect_pc;
                end else if ({out_rd, out_rd_wen, out_rd_data, out_redirect, out_redirect_pc}
                             !== {o_rd, o_rdwen, o_rddata, o_redir, o_rpc}) begin
                    unstable = 1;
                end
                if (stl == v.stall) begin
                    out_ready = 1;
                    @(negedge clock);
                    out_ready = 0;
                    if (csr_wen)   nwen++;
                    if (csr_ecall) nec++;
                    if (csr_mret)  nmr++;
                    pv = out_valid; pr = in_ready; done = 1;
                end else begin
                    stl++;
                end
            end
        end
        chk("handshake_done", 32'(done), 1);
        chk("latency", lat, 2);
        chk("wen_pulses", nwen, 32'(v.e_wen));
        if (v.e_wen) begin
            chk("csr_waddr", waddr, 32'(v.addr));
            chk("csr_wdata", wdata, v.e_wdata);
        end
        chk("ecall_pulses", nec, 32'(v.e_ec));
        if (v.e_ec) chk("csr_pc", cpc, v.pc);
        chk("mret_pulses", nmr, 32'(v.e_mr));
        chk("out_rd", 32'(o_rd), 32'(v.rd));
        chk("out_rd_wen", 32'(o_rdwen), 32'(v.e_rdwen));
        if (v.e_csrop) chk("out_rd_data", o_rddata, v.e_rddata);
        chk("out_redirect", 32'(o_redir), 32'(v.e_redir));
        if (v.e_redir) chk("out_redirect_pc", o_rpc, v.e_rpc);
        chk("out_stable", 32'(unstable), 0);
        chk("in_ready_busy", 32'(rdybad), 0);
        chk("valid_drop", 32'(pv), 0);
        chk("ready_back", 32'(pr), 1);
        n_vec++;
    endtask

    vec_t tbl[11];

    initial begin
        int nw;
        vec_t v;
        reset = 0; in_valid = 0; out_ready = 0; in_pc = 0; in_funct3 = 0;
        in_is_ecall = 0; in_is_mret = 0; in_csr_addr = 0; in_rs1_idx = 0;
        in_rs1_data = 0; in_rd = 0; csr_mepc = 0; csr_mtvec = 0;
        cur_addr = 12'hFFF; cur_old = 0;

        tbl[0]  = ex(mk(3'b001, 0, 0, 12'h305, 5'd1, 32'h8000_0100, 5'd5, 32'h100, 32'h0, 0, 0, 0),
                     1, 32'h8000_0100, 0, 0, 1, 1, 32'h0, 0, 0);
        tbl[1]  = ex(mk(3'b010, 0, 0, 12'h300, 5'd0, 32'hFFFF_FFFF, 5'd7, 32'h104, 32'h1800, 0, 0, 0),
                     0, 0, 0, 0, 1, 1, 32'h1800, 0, 0);
        tbl[2]  = ex(mk(3'b111, 0, 0, 12'h300, 5'd3, 32'h0, 5'd0, 32'h108, 32'hF, 0, 0, 1),
                     1, 32'hC, 0, 0, 1, 0, 32'hF, 0, 0);
        tbl[3]  = ex(mk(3'b000, 1, 0, 12'h000, 5'd0, 32'h0, 5'd0, 32'h8000_0020, 32'h0, 32'h8000_0400, 32'h0, 0),
                     0, 0, 1, 0, 0, 0, 0, 1, 32'h8000_0400);
        tbl[4]  = ex(mk(3'b000, 0, 1, 12'h000, 5'd0, 32'h0, 5'd0, 32'h8000_0400, 32'h0, 32'h0, 32'h8000_0020, 2),
                     0, 0, 0, 1, 0, 0, 0, 1, 32'h8000_0020);
        tbl[5]  = ex(mk(3'b001, 0, 0, 12'h340, 5'd9, 32'h1234_5678, 5'd3, 32'h200, 32'hAAAA, 0, 0, 5),
                     1, 32'h1234_5678, 0, 0, 1, 1, 32'hAAAA, 0, 0);
        tbl[6]  = ex(mk(3'b000, 1, 1, 12'h000, 5'd0, 32'h0, 5'd0, 32'h300, 32'h0, 32'h8000_0800, 32'h8000_0900, 0),
                     0, 0, 1, 0, 0, 0, 0, 1, 32'h8000_0800);
        tbl[7]  = ex(mk(3'b100, 0, 0, 12'h305, 5'd4, 32'h55, 5'd9, 32'h304, 32'h77, 0, 0, 0),
                     0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[8]  = ex(mk(3'b110, 0, 0, 12'h344, 5'd31, 32'h0, 5'd2, 32'h308, 32'h100, 0, 0, 0),
                     1, 32'h11F, 0, 0, 1, 1, 32'h100, 0, 0);
        tbl[9]  = ex(mk(3'b011, 0, 0, 12'h304, 5'd8, 32'hFFFF_FFFF, 5'd31, 32'h30C, 32'hFFFF, 0, 0, 0),
                     1, 32'h0, 0, 0, 1, 1, 32'hFFFF, 0, 0);
        tbl[10] = ex(mk(3'b101, 0, 0, 12'h341, 5'd0, 32'hFFFF_FFFF, 5'd1, 32'h310, 32'hABCD, 0, 0, 3),
                     1, 32'h0, 0, 0, 1, 1, 32'hABCD, 0, 0);

        repeat (2) @(negedge clock);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_pulses", {29'd0, csr_wen, csr_ecall, csr_mret}, 0);
        chk("rst_out_fields", {out_rd_wen, out_redirect, out_rd_data[29:0]}, 0);
        chk("rst_csr_addr_pc", {csr_raddr, csr_waddr, csr_pc[7:0]}, 0);
        reset = 1;
        @(negedge clock);

        foreach (tbl[i]) apply(tbl[i]);

        // Reset while the write pulse is live
        cur_addr = 12'h305; cur_old = 32'h0;
        in_funct3 = 3'b001; in_is_ecall = 0; in_is_mret = 0; in_csr_addr = 12'h305;
        in_rs1_idx = 5'd1; in_rs1_data = 32'h8000_0100; in_rd = 5'd5; in_valid = 1;
        @(negedge clock);
        in_valid = 0;
        chk("exec_wen_live", csr_wen, 1);
        reset = 0;
        #1;
        chk("rst_cut_wen", csr_wen, 0);
        chk("rst_cut_valid", out_valid, 0);
        chk("rst_cut_ready", in_ready, 1);
        @(negedge clock);
        reset = 1;
        nw = 0;
        repeat (4) begin
            @(negedge clock);
            if (csr_wen || csr_ecall || csr_mret) nw++;
        end
        chk("rst_no_pulse", nw, 0);
        chk("rst_idle_valid", out_valid, 0);
        chk("rst_idle_ready", in_ready, 1);
        n_vec++;

        for (int i = 0; i < 150; i++) begin
            v = mk(3'($urandom_range(0, 7)), ($urandom_range(0, 7) == 0),
                   ($urandom_range(0, 7) == 0), 12'($urandom),
                   ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
                   $urandom, ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
                   $urandom, $urandom, $urandom, $urandom, int'($urandom_range(0, 3)));
            apply(model(v));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
